// File: rtl/game_pkg.sv
// Shared game constants and types.
// Screen geometry, target width and the paddle FSM states.
package game_pkg;

   localparam int SCR_W   = 640;
   localparam int SCR_H   = 480;
   localparam int COORD_W = 10;
   localparam int TGT_W   = 8;

   typedef enum logic [1:0] {
      HOLD,
      UP,
      DOWN
   } pstate_t;

endpackage

// File: rtl/rect_hit.sv
// Registered point-in-rectangle test for sprite rendering.
// Ports: clk, reset_n, x0/y0/w/h rect, pix_x/pix_y/pix_valid scan in, hit out.
module rect_hit
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               pix_valid,
   output logic               hit
);

   // One extra bit so the right/bottom edge never wraps.
   logic [COORD_W:0] w_x_end;
   logic [COORD_W:0] w_y_end;
   logic             w_in_x;
   logic             w_in_y;
   logic             r_hit;

   always_comb begin
      w_x_end = {1'b0, x0} + {1'b0, w};
      w_y_end = {1'b0, y0} + {1'b0, h};
      w_in_x  = (pix_x >= x0) && ({1'b0, pix_x} < w_x_end);
      w_in_y  = (pix_y >= y0) && ({1'b0, pix_y} < w_y_end);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hit <= 1'b0;
      end else begin
         r_hit <= pix_valid && w_in_x && w_in_y;
      end
   end

   assign hit = r_hit;

endmodule

// File: rtl/paddle_tracker.sv
// Slews the displayed paddle toward the latched target once per frame.
// Ports: target_y/frame_tick in, pix_* scan in, paddle_y/moving/pixel_on out.
module paddle_tracker
   import game_pkg::*;
#(
   parameter int Y_MAX    = 200,
   parameter int Y_RESET  = 100,
   parameter int STEP     = 2,
   parameter int Y_SHIFT  = 1,
   parameter int PADDLE_X = 600,
   parameter int PADDLE_W = 8,
   parameter int PADDLE_H = 40
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [TGT_W-1:0]   target_y,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               pix_valid,
   output logic [TGT_W-1:0]   paddle_y,
   output logic               moving,
   output logic               pixel_on
);

   localparam logic [TGT_W-1:0] YMAX8 = TGT_W'(Y_MAX);
   localparam logic [TGT_W-1:0] YRST8 = TGT_W'(Y_RESET);
   localparam logic [8:0]       STEP9 = 9'(STEP);

   logic [TGT_W-1:0]   r_tgt;
   logic [TGT_W-1:0]   r_py;
   logic               r_pend;
   pstate_t            r_state;

   logic signed [8:0]  w_diff;
   logic [8:0]         w_mag;
   logic [TGT_W-1:0]   w_amt;
   logic [TGT_W-1:0]   w_tgt_clamp;
   pstate_t            w_dir;
   pstate_t            w_state_nx;
   logic [TGT_W-1:0]   w_py_nx;
   logic [COORD_W-1:0] w_top;

   assign w_tgt_clamp = (target_y > YMAX8) ? YMAX8 : target_y;

   // Direction toward target and clipped step size.
   always_comb begin
      w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_py});
      w_mag  = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
      w_amt  = (w_mag > STEP9) ? STEP9[TGT_W-1:0] : w_mag[TGT_W-1:0];
      w_dir  = HOLD;
      if (w_diff > 0) begin
         w_dir = DOWN;
      end else if (w_diff < 0) begin
         w_dir = UP;
      end
   end

   // Move is applied only in the cycle after a latch.
   always_comb begin
      w_py_nx    = r_py;
      w_state_nx = r_state;
      if (r_pend) begin
         unique case (w_dir)
            DOWN:    w_py_nx = r_py + w_amt;
            UP:      w_py_nx = r_py - w_amt;
            default: w_py_nx = r_py;
         endcase
         w_state_nx = (w_py_nx == r_tgt) ? HOLD : w_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= HOLD;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // A tick during the pending move is dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tgt  <= YRST8;
         r_py   <= YRST8;
         r_pend <= 1'b0;
      end else begin
         r_py <= w_py_nx;
         if (r_pend) begin
            r_pend <= 1'b0;
         end else if (frame_tick) begin
            r_pend <= 1'b1;
            r_tgt  <= w_tgt_clamp;
         end
      end
   end

   assign w_top = COORD_W'({2'b00, r_py} << Y_SHIFT);

   rect_hit u_hit (
      .clk       (clk),
      .reset_n   (reset_n),
      .x0        (COORD_W'(PADDLE_X)),
      .y0        (w_top),
      .w         (COORD_W'(PADDLE_W)),
      .h         (COORD_W'(PADDLE_H)),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_valid (pix_valid),
      .hit       (pixel_on)
   );

   assign paddle_y = r_py;
   // State is HOLD exactly when the last move landed on the target.
   assign moving   = (r_state != HOLD);

endmodule

// File: tb/tb_paddle_tracker.sv
// Bench for paddle_tracker with a frame-level model.
// Directed stimulus plus literal pins on the model.
module tb_paddle_tracker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] target_y;
   logic       frame_tick;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_valid;
   logic [7:0] paddle_y;
   logic       moving;
   logic       pixel_on;

   int n_pass = 0;
   int n_tot  = 0;
   bit chk_en = 0;

   int m_py, m_tgt, m_mov, m_pix, m_busy;

   always #5 clk = ~clk;

   paddle_tracker dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .target_y   (target_y),
      .frame_tick (frame_tick),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_valid  (pix_valid),
      .paddle_y   (paddle_y),
      .moving     (moving),
      .pixel_on   (pixel_on)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Frame-level model: a tick latches the clamped target, the next
   // clock edge moves at most 2 units toward it.
   always @(posedge clk) begin
      int top, d;
      if (!reset_n) begin
         m_py = 100; m_tgt = 100; m_mov = 0; m_pix = 0; m_busy = 0;
      end else begin
         top = m_py * 2;
         m_pix = (pix_valid && pix_x >= 600 && pix_x < 608 &&
                  pix_y >= top && pix_y < top + 40) ? 1 : 0;
         if (m_busy != 0) begin
            d = m_tgt - m_py;
            if (d > 2) d = 2;
            if (d < -2) d = -2;
            m_py = m_py + d;
            m_mov = (m_py != m_tgt) ? 1 : 0;
            m_busy = 0;
         end else if (frame_tick) begin
            m_tgt = (target_y > 200) ? 200 : int'(target_y);
            m_busy = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_paddle_y", int'(paddle_y), m_py);
         chk("cyc_moving", int'(moving), m_mov);
         chk("cyc_pixel_on", int'(pixel_on), m_pix);
         if (paddle_y > 200) chk("cyc_range", int'(paddle_y), 200);
      end
   end

   task automatic tick();
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic scan(input int x, input int y, input bit v,
                       input int exp, input string nm);
      @(posedge clk); #1;
      pix_x = 10'(x); pix_y = 10'(y); pix_valid = v;
      @(posedge clk); #1;
      chk(nm, int'(pixel_on), exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; target_y = 8'd100; frame_tick = 1'b0;
      pix_x = '0; pix_y = '0; pix_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk_en = 1;
      chk("rst_paddle_y", int'(paddle_y), 100);
      chk("rst_moving", int'(moving), 0);
      chk("rst_pixel_on", int'(pixel_on), 0);

      ticks(3);
      chk("idle_paddle_y", int'(paddle_y), 100);
      chk("idle_model", m_py, 100);

      target_y = 8'd110;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("step_paddle_y", int'(paddle_y), 100 + 2 * k);
         chk("step_moving", int'(moving), (k < 5) ? 1 : 0);
      end

      target_y = 8'd255;
      ticks(44);
      chk("clamp_mid", int'(paddle_y), 198);
      chk("clamp_mid_moving", int'(moving), 1);
      tick();
      chk("clamp_end", int'(paddle_y), 200);
      chk("clamp_end_moving", int'(moving), 0);
      ticks(2);
      chk("clamp_hold", int'(paddle_y), 200);
      chk("clamp_model", m_py, 200);

      do_reset();
      target_y = 8'd101;
      tick();
      chk("snap_paddle_y", int'(paddle_y), 101);
      chk("snap_moving", int'(moving), 0);
      target_y = 8'd50;
      repeat (6) @(posedge clk);
      #1 chk("ignore_midframe", int'(paddle_y), 101);
      tick();
      chk("after_tick_99", int'(paddle_y), 99);

      target_y = 8'd60;
      ticks(20);
      chk("at_60", int'(paddle_y), 60);
      chk("at_60_model", m_py, 60);
      scan(600, 120, 1'b1, 1, "pix_hit");
      scan(608, 120, 1'b1, 0, "pix_right");
      scan(600, 160, 1'b1, 0, "pix_bottom");
      scan(599, 140, 1'b1, 0, "pix_left");
      scan(607, 159, 1'b1, 1, "pix_corner");
      scan(600, 120, 1'b0, 0, "pix_invalid");

      do_reset();
      target_y = 8'd30;
      ticks(10);
      chk("mid_80", int'(paddle_y), 80);
      chk("mid_80_moving", int'(moving), 1);
      scan(600, 170, 1'b1, 1, "mid_pix");
      @(posedge clk); #1;
      reset_n = 1'b0; frame_tick = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_paddle_y", int'(paddle_y), 100);
      chk("rst_mid_moving", int'(moving), 0);
      chk("rst_mid_pixel_on", int'(pixel_on), 0);
      reset_n = 1'b1; frame_tick = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("tick_in_reset_dropped", int'(paddle_y), 100);
      chk("tick_in_reset_moving", int'(moving), 0);
      tick();
      chk("after_reset_move", int'(paddle_y), 98);

      @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
